mem_bus_arbiter: RTL

- Shares one external memory bus between the instruction-fetch port (pc_reg/if_id side) and the data-access port (mem stage).
- Sequences one bus transaction at a time.
- Returns captured read data to the winning requester.
- Raises per-port stall requests that freeze the pipeline until that port's access completes.

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter: bus widths, enable
// encodings, the arbiter state encoding and the default timeout.
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  localparam int REG_BUS_W   = 32;   // general register / data bus width
  localparam int INST_ADDR_W = 32;   // instruction address bus width

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam logic [3:0] SEL_ALL = 4'b1111;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one external memory bus between the instruction-fetch port and the
// data-access port. One bus transaction runs at a time; data requests win
// over fetches because they belong to the older instruction. Read data is
// captured on ack and returned to the requester, and each port raises a
// stall request until its own access has completed.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   if_ce_i/if_addr_i  fetch request level and address
//   if_data_o          fetched word (valid in the cycle if_done is high)
//   if_stall_req_o     fetch not yet satisfied
//   flush_i            discard an in-flight fetch result
//   d_ce_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i   data access request
//   d_rdata_o          read data (valid in the cycle d_done is high)
//   d_stall_req_o      data access not yet satisfied
//   bus_*_o            registered bus request, write strobe, lanes, address,
//                      write data
//   bus_rdata_i/bus_ack_i  read data and single-cycle completion
//   bus_err_o          sticky timeout flag
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
  parameter int ADDR_W      = INST_ADDR_W,
  parameter int DATA_W      = REG_BUS_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stall_req_o,
  input  logic              flush_i,

  input  logic              d_ce_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_req_o,

  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  // The counter terminates the transaction in the busy cycle in which it
  // would reach TIMEOUT_CYC, so the compare is against TIMEOUT_CYC-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  arb_state_e        state_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [3:0]        bus_sel_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              discard_q;
  logic              bus_err_q;
  logic [7:0]        tmo_cnt_q;

  logic              tmo_hit;
  logic              finish;
  logic [DATA_W-1:0] rdata_cap;
  logic              drop_fetch;

  assign tmo_hit    = (tmo_cnt_q == TMO_LAST);
  // Ack wins over a simultaneous timeout; a timeout completes with zero data.
  assign finish     = bus_ack_i | tmo_hit;
  assign rdata_cap  = bus_ack_i ? bus_rdata_i : '0;
  // A flush in the completing cycle counts the same as an earlier one.
  assign drop_fetch = discard_q | flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      discard_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      // Done flags are single-cycle pulses; a flush outside BUSY_I therefore
      // never has a pending done flag left to clear beyond this cycle.
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          tmo_cnt_q <= '0;
          // A port whose done flag is high is consuming its result now and
          // must not be re-granted for the same request.
          if (d_ce_i == CHIP_ENABLE && !d_done_q) begin
            state_q     <= ST_BUSY_D;
            bus_req_q   <= 1'b1;
            bus_we_q    <= d_we_i;
            bus_sel_q   <= d_sel_i;
            bus_addr_q  <= d_addr_i;
            bus_wdata_q <= d_wdata_i;
          end else if (if_ce_i == CHIP_ENABLE && !if_done_q) begin
            state_q     <= ST_BUSY_I;
            bus_req_q   <= 1'b1;
            bus_we_q    <= ~WRITE_ENABLE;
            bus_sel_q   <= SEL_ALL;
            bus_addr_q  <= if_addr_i;
            bus_wdata_q <= '0;
            discard_q   <= flush_i;
          end
        end

        ST_BUSY_I: begin
          if (finish) begin
            state_q   <= ST_IDLE;
            bus_req_q <= 1'b0;
            if (!bus_ack_i) bus_err_q <= 1'b1;
            // The bus cannot be aborted, so a flushed fetch still runs to
            // completion and only its result is thrown away here.
            if (drop_fetch) begin
              discard_q <= 1'b0;
            end else begin
              if_data_q <= rdata_cap;
              if_done_q <= 1'b1;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
            if (flush_i) discard_q <= 1'b1;
          end
        end

        ST_BUSY_D: begin
          if (finish) begin
            state_q   <= ST_IDLE;
            bus_req_q <= 1'b0;
            if (!bus_ack_i) bus_err_q <= 1'b1;
            d_rdata_q <= rdata_cap;
            d_done_q  <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_stall_req_o = if_ce_i & ~if_done_q;
  assign d_stall_req_o  = d_ce_i & ~d_done_q;

  assign if_data_o   = if_data_q;
  assign d_rdata_o   = d_rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_err_o   = bus_err_q;

endmodule
